// File: rtl/traffic_light_pkg.sv
// Shared phase encoding, monitor states and phase-sequence helpers for the
// intersection light controller and its observers.
package traffic_light_pkg;

  localparam logic [1:0] S_RED     = 2'b00;
  localparam logic [1:0] S_GREEN   = 2'b01;
  localparam logic [1:0] S_YELLOW  = 2'b10;
  localparam logic [1:0] S_INVALID = 2'b11;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } mon_state_e;

  function automatic logic [1:0] legal_next(input logic [1:0] ph);
    case (ph)
      S_RED:    return S_GREEN;
      S_GREEN:  return S_YELLOW;
      S_YELLOW: return S_RED;
      default:  return S_INVALID;
    endcase
  endfunction

  function automatic int unsigned expected_time(input logic [1:0]  ph,
                                                input int unsigned red_t,
                                                input int unsigned green_t,
                                                input int unsigned yellow_t);
    case (ph)
      S_RED:    return red_t;
      S_GREEN:  return green_t;
      S_YELLOW: return yellow_t;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/light_decode.sv
// Combinational decode of a {red, yellow, green} light vector into a phase;
// anything that is not exactly one lamp decodes as S_INVALID.
module light_decode
  import traffic_light_pkg::*;
(
  input  logic [2:0] lights,
  output logic [1:0] phase
);

  always_comb begin
    phase = S_INVALID;
    case (lights)
      3'b100:  phase = S_RED;
      3'b001:  phase = S_GREEN;
      3'b010:  phase = S_YELLOW;
      default: phase = S_INVALID;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Receiving-end checker for the intersection light outputs: locks onto the
// phase sequence, checks one-hot, order and dwell, and keeps sticky errors.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int unsigned RED_TIME    = 10,
  parameter int unsigned GREEN_TIME  = 8,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned CYC_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             locked,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_dur,
  output logic             fault_pulse,
  output logic [CYC_W-1:0] cycle_count,
  output logic [CNT_W-1:0] dur_last
);

  logic [2:0]       l_d, l_q;
  logic [1:0]       dec;
  logic [1:0]       phase_d, phase_q;
  logic [1:0]       prev_d, prev_q;
  logic [1:0]       warm_d, warm_q;
  logic [CNT_W-1:0] run_d, run_q;
  mon_state_e       state_d, state_q;
  logic             err_onehot_d, err_onehot_q;
  logic             err_seq_d, err_seq_q;
  logic             err_dur_d, err_dur_q;
  logic             fault_pulse_d, fault_pulse_q;
  logic [CYC_W-1:0] cycle_count_d, cycle_count_q;
  logic [CNT_W-1:0] dur_last_d, dur_last_q;

  logic             any_chg, valid_chg, tracking;
  logic             det_onehot, det_seq, det_dur;
  logic [CNT_W-1:0] exp_old, exp_stuck;

  light_decode u_decode (
    .lights (l_q),
    .phase  (dec)
  );

  always_comb begin
    l_d     = {red, yellow, green};
    phase_d = dec;
    prev_d  = phase_q;
    // The reset value of l_q decodes as INVALID; the one-hot check waits until
    // phase_q holds a decode of a genuinely sampled light vector.
    warm_d  = {warm_q[0], 1'b1};

    any_chg   = (phase_q != prev_q);
    valid_chg = any_chg && (phase_q != S_INVALID) && (prev_q != S_INVALID);
    run_d     = any_chg ? CNT_W'(1)
                        : ((run_q == '1) ? run_q : run_q + CNT_W'(1));

    exp_old   = CNT_W'(expected_time(prev_q, RED_TIME, GREEN_TIME, YELLOW_TIME));
    exp_stuck = CNT_W'(expected_time(phase_q, RED_TIME, GREEN_TIME, YELLOW_TIME) + 1);

    tracking   = (state_q == TRACK);
    det_onehot = warm_q[1] && (phase_q == S_INVALID);
    det_seq    = tracking && valid_chg && (phase_q != legal_next(prev_q));
    det_dur    = tracking &&
                 ((valid_chg && (run_q != exp_old)) ||
                  (!any_chg && (phase_q != S_INVALID) && (run_q == exp_stuck)));

    state_d       = state_q;
    fault_pulse_d = 1'b0;
    case (state_q)
      SYNC:  if (valid_chg) state_d = TRACK;
      TRACK: if (det_onehot || det_seq || det_dur) begin
               state_d       = FAULT;
               fault_pulse_d = 1'b1;
             end
      FAULT: state_d = FAULT;
      default: state_d = SYNC;
    endcase
    if (clr_err) begin
      state_d       = SYNC;
      fault_pulse_d = 1'b0;
    end

    // A detection in the clearing cycle still lands in the flag.
    err_onehot_d = (err_onehot_q && !clr_err) || det_onehot;
    err_seq_d    = (err_seq_q    && !clr_err) || det_seq;
    err_dur_d    = (err_dur_q    && !clr_err) || det_dur;

    cycle_count_d = cycle_count_q;
    if (tracking && valid_chg && (prev_q == S_YELLOW) && (phase_q == S_RED))
      cycle_count_d = cycle_count_q + CYC_W'(1);

    dur_last_d = dur_last_q;
    if (valid_chg && (state_q != SYNC))
      dur_last_d = run_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_q           <= '0;
      phase_q       <= S_INVALID;
      prev_q        <= S_INVALID;
      warm_q        <= '0;
      run_q         <= '0;
      state_q       <= SYNC;
      err_onehot_q  <= 1'b0;
      err_seq_q     <= 1'b0;
      err_dur_q     <= 1'b0;
      fault_pulse_q <= 1'b0;
      cycle_count_q <= '0;
      dur_last_q    <= '0;
    end else begin
      l_q           <= l_d;
      phase_q       <= phase_d;
      prev_q        <= prev_d;
      warm_q        <= warm_d;
      run_q         <= run_d;
      state_q       <= state_d;
      err_onehot_q  <= err_onehot_d;
      err_seq_q     <= err_seq_d;
      err_dur_q     <= err_dur_d;
      fault_pulse_q <= fault_pulse_d;
      cycle_count_q <= cycle_count_d;
      dur_last_q    <= dur_last_d;
    end
  end

  assign phase       = phase_q;
  assign locked      = (state_q == TRACK);
  assign err_onehot  = err_onehot_q;
  assign err_seq     = err_seq_q;
  assign err_dur     = err_dur_q;
  assign fault_pulse = fault_pulse_q;
  assign cycle_count = cycle_count_q;
  assign dur_last    = dur_last_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: segment table plus per-cycle
// sequences for stuck lamps, glitches, clears and mid-run reset.
module tb_traffic_light_monitor;
  import traffic_light_pkg::*;

  localparam int unsigned CNT_W = 5;
  localparam int unsigned CYC_W = 16;
  localparam logic [2:0]  LR = 3'b100;
  localparam logic [2:0]  LG = 3'b001;
  localparam logic [2:0]  LY = 3'b010;

  logic             clk = 1'b0;
  logic             rst, red, yellow, green, clr_err;
  logic [1:0]       phase;
  logic             locked, err_onehot, err_seq, err_dur, fault_pulse;
  logic [CYC_W-1:0] cycle_count;
  logic [CNT_W-1:0] dur_last;

  typedef struct packed {
    logic [1:0]  ph;
    logic        lk;
    logic        eo;
    logic        es;
    logic        ed;
    logic        fp;
    logic [15:0] cc;
    logic [4:0]  dur;
  } obs_t;

  typedef struct {
    int          id;
    logic [2:0]  lights;
    logic        r;
    logic        c;
    int unsigned n;
    obs_t        e;
  } vec_t;

  vec_t  tbl [21];
  obs_t  sb_q [$];
  string nm_q [$];
  int    checks   = 0;
  int    failures = 0;

  traffic_light_monitor #(
    .RED_TIME    (10),
    .GREEN_TIME  (8),
    .YELLOW_TIME (3),
    .CNT_W       (CNT_W),
    .CYC_W       (CYC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .clr_err     (clr_err),
    .phase       (phase),
    .locked      (locked),
    .err_onehot  (err_onehot),
    .err_seq     (err_seq),
    .err_dur     (err_dur),
    .fault_pulse (fault_pulse),
    .cycle_count (cycle_count),
    .dur_last    (dur_last)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [1:0] ph, input int lk, input int eo,
                              input int es, input int ed, input int fp,
                              input int cc, input int dur);
    obs_t o;
    o.ph  = ph;
    o.lk  = (lk != 0);
    o.eo  = (eo != 0);
    o.es  = (es != 0);
    o.ed  = (ed != 0);
    o.fp  = (fp != 0);
    o.cc  = cc[15:0];
    o.dur = dur[4:0];
    return o;
  endfunction

  task automatic check_pop();
    obs_t  act, exp_o;
    string nm;
    act = {phase, locked, err_onehot, err_seq, err_dur, fault_pulse, cycle_count, dur_last};
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: output sampled with no expectation queued");
    end else begin
      exp_o = sb_q.pop_front();
      nm    = nm_q.pop_front();
      if (act !== exp_o) begin
        failures++;
        $display("FAIL %s: got ph=%b lk=%b eo=%b es=%b ed=%b fp=%b cc=%0d dur=%0d, want ph=%b lk=%b eo=%b es=%b ed=%b fp=%b cc=%0d dur=%0d",
                 nm, act.ph, act.lk, act.eo, act.es, act.ed, act.fp, act.cc, act.dur,
                 exp_o.ph, exp_o.lk, exp_o.eo, exp_o.es, exp_o.ed, exp_o.fp, exp_o.cc, exp_o.dur);
      end
    end
  endtask

  // Drive one input setting for n edges, then compare against the queued expectation.
  task automatic run_seg(input string nm, input logic [2:0] lt, input logic r,
                         input logic c, input int unsigned n, input obs_t e);
    {red, yellow, green} = lt;
    rst     = r;
    clr_err = c;
    sb_q.push_back(e);
    nm_q.push_back(nm);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    check_pop();
  endtask

  task automatic run_entry(input vec_t v);
    run_seg($sformatf("seg_%0d", v.id), v.lights, v.r, v.c, v.n, v.e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr_err = 1'b0; {red, yellow, green} = LR;

    tbl[0]  = '{0,  LR, 1'b1, 1'b0, 3,  mk(S_INVALID, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1,  LR, 1'b0, 1'b0, 10, mk(S_RED,    0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{2,  LG, 1'b0, 1'b0, 8,  mk(S_GREEN,  1, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{3,  LY, 1'b0, 1'b0, 3,  mk(S_YELLOW, 1, 0, 0, 0, 0, 0, 8)};
    tbl[4]  = '{4,  LR, 1'b0, 1'b0, 10, mk(S_RED,    1, 0, 0, 0, 0, 1, 3)};
    tbl[5]  = '{5,  LG, 1'b0, 1'b0, 8,  mk(S_GREEN,  1, 0, 0, 0, 0, 1, 10)};
    tbl[6]  = '{6,  LY, 1'b0, 1'b0, 3,  mk(S_YELLOW, 1, 0, 0, 0, 0, 1, 8)};
    tbl[7]  = '{7,  LR, 1'b0, 1'b0, 10, mk(S_RED,    1, 0, 0, 0, 0, 2, 3)};
    tbl[8]  = '{8,  LG, 1'b0, 1'b0, 8,  mk(S_GREEN,  1, 0, 0, 0, 0, 2, 10)};
    tbl[9]  = '{9,  LY, 1'b0, 1'b0, 3,  mk(S_YELLOW, 1, 0, 0, 0, 0, 2, 8)};
    tbl[10] = '{10, LR, 1'b0, 1'b0, 10, mk(S_RED,    1, 0, 0, 0, 0, 3, 3)};
    tbl[11] = '{11, LG, 1'b0, 1'b0, 8,  mk(S_GREEN,  1, 0, 0, 0, 0, 3, 10)};
    tbl[12] = '{12, LY, 1'b0, 1'b0, 3,  mk(S_YELLOW, 1, 0, 0, 0, 0, 3, 8)};
    tbl[13] = '{13, LR, 1'b0, 1'b0, 10, mk(S_RED,    1, 0, 0, 0, 0, 4, 3)};
    tbl[14] = '{14, LG, 1'b0, 1'b0, 7,  mk(S_GREEN,  1, 0, 0, 0, 0, 4, 10)};
    tbl[15] = '{15, LY, 1'b0, 1'b0, 3,  mk(S_YELLOW, 0, 0, 0, 1, 1, 4, 7)};
    tbl[16] = '{16, LY, 1'b0, 1'b1, 1,  mk(S_YELLOW, 0, 0, 0, 0, 0, 4, 7)};
    tbl[17] = '{17, LR, 1'b0, 1'b0, 10, mk(S_RED,    1, 0, 0, 0, 0, 4, 7)};
    tbl[18] = '{18, LG, 1'b0, 1'b0, 8,  mk(S_GREEN,  1, 0, 0, 0, 0, 4, 10)};
    tbl[19] = '{19, LR, 1'b0, 1'b0, 4,  mk(S_RED,    0, 0, 1, 0, 0, 4, 8)};
    tbl[20] = '{20, LR, 1'b0, 1'b1, 1,  mk(S_RED,    0, 0, 0, 0, 0, 4, 8)};

    for (int i = 0; i < 21; i++) run_entry(tbl[i]);

    // Two lamps for one cycle while unlocked: one INVALID phase, sticky one-hot error.
    for (int i = 1; i <= 5; i++)
      run_seg($sformatf("glitch_%0d", i), (i == 1) ? 3'b110 : LR, 1'b0, 1'b0, 1,
              mk((i == 2) ? S_INVALID : S_RED, 0, (i >= 3) ? 1 : 0, 0, 0, 0, 4, 8));

    // Clear, then let clr_err coincide with the one-hot detection.
    run_seg("clr_a", LR, 1'b0, 1'b1, 1, mk(S_RED, 0, 0, 0, 0, 0, 4, 8));
    for (int i = 1; i <= 4; i++)
      run_seg($sformatf("clr_coinc_%0d", i), (i == 1) ? 3'b011 : LR, 1'b0,
              (i == 3) ? 1'b1 : 1'b0, 1,
              mk((i == 2) ? S_INVALID : S_RED, 0, (i >= 3) ? 1 : 0, 0, 0, 0, 4, 8));
    run_seg("clr_b", LR, 1'b0, 1'b1, 1, mk(S_RED, 0, 0, 0, 0, 0, 4, 8));

    // Relock, then hold red 20 cycles: dwell error once run hits RED_TIME+1.
    run_seg("relock_g", LG, 1'b0, 1'b0, 8, mk(S_GREEN,  1, 0, 0, 0, 0, 4, 8));
    run_seg("relock_y", LY, 1'b0, 1'b0, 3, mk(S_YELLOW, 1, 0, 0, 0, 0, 4, 8));
    for (int i = 1; i <= 20; i++)
      run_seg($sformatf("stuck_%0d", i), LR, 1'b0, 1'b0, 1,
              mk((i == 1) ? S_YELLOW : S_RED, (i < 14) ? 1 : 0, 0, 0,
                 (i >= 14) ? 1 : 0, (i == 14) ? 1 : 0,
                 (i >= 3) ? 5 : 4, (i >= 3) ? 3 : 8));

    // Green after the fault: no second pulse, dur_last still records the dwell.
    for (int i = 1; i <= 8; i++)
      run_seg($sformatf("post_fault_%0d", i), LG, 1'b0, 1'b0, 1,
              mk((i == 1) ? S_RED : S_GREEN, 0, 0, 0, 1, 0, 5, (i >= 3) ? 20 : 3));

    run_seg("fault_clr", LG, 1'b0, 1'b1, 1, mk(S_GREEN,  0, 0, 0, 0, 0, 5, 20));
    run_seg("resync_y",  LY, 1'b0, 1'b0, 3, mk(S_YELLOW, 1, 0, 0, 0, 0, 5, 20));
    run_seg("resync_r",  LR, 1'b0, 1'b0, 10, mk(S_RED,   1, 0, 0, 0, 0, 6, 3));

    // Fresh start to cycle_count=2, then reset in the middle of green.
    for (int i = 0; i < 8; i++) run_entry(tbl[i]);
    run_seg("mid_green",  LG, 1'b0, 1'b0, 4, mk(S_GREEN,   1, 0, 0, 0, 0, 2, 10));
    run_seg("rst_pulse",  LG, 1'b1, 1'b0, 1, mk(S_INVALID, 0, 0, 0, 0, 0, 0, 0));
    run_seg("after_rst",  LG, 1'b0, 1'b0, 4, mk(S_GREEN,   0, 0, 0, 0, 0, 0, 0));
    run_seg("relock2_y",  LY, 1'b0, 1'b0, 3, mk(S_YELLOW,  1, 0, 0, 0, 0, 0, 0));
    run_seg("relock2_r",  LR, 1'b0, 1'b0, 10, mk(S_RED,    1, 0, 0, 0, 0, 1, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Receiving-end checker for the red/yellow/green light outputs of the intersection controller.
- Decodes the three lights into a phase and synchronises to the phase sequence.
- Checks one-hot encoding, the RED->GREEN->YELLOW->RED order, and the exact dwell of each phase against configured times.
- Reports sticky errors plus cycle statistics to the supervisor/status logic.

Parameters:
RED_TIME, 10, expected RED dwell in clk cycles
GREEN_TIME, 8, expected GREEN dwell in clk cycles
YELLOW_TIME, 3, expected YELLOW dwell in clk cycles
CNT_W, 5, phase run-counter width; must hold max(*_TIME)+1
CYC_W, 16, completed-cycle counter width

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  synchronous reset, active-high
red  in  1  observed red light
yellow  in  1  observed yellow light
green  in  1  observed green light
clr_err  in  1  clear sticky errors, resynchronise
phase  out  2  decoded phase: 00 RED, 01 GREEN, 10 YELLOW, 11 INVALID
locked  out  1  high while in TRACK
err_onehot  out  1  sticky: light vector not one-hot
err_seq  out  1  sticky: illegal phase successor
err_dur  out  1  sticky: phase dwell mismatch
fault_pulse  out  1  one-cycle pulse on entry to FAULT
cycle_count  out  CYC_W  completed RED/GREEN/YELLOW cycles while locked
dur_last  out  CNT_W  dwell of the last completed phase

Behaviour:
- Reset (rst=1 at a clk edge) forces the following values:
  - state=SYNC, phase=11, locked=0, all err_*=0, fault_pulse=0, cycle_count=0, dur_last=0.
  - Run counter=0; input register=000.
- Inputs are registered once (l_q).
- Decode is combinational on l_q:
  - 100 -> RED; 001 -> GREEN; 010 -> YELLOW; any other value -> INVALID.
  - phase is the registered decode, so it is 2 clk behind the pins.
  - Flags are registered, so a fault present on the pins before edge N is visible after edge N+2.
- Run counter:
  - Loads 1 on a phase change.
  - Otherwise increments, saturating at 2^CNT_W-1.
  - Counts in every state.
- SYNC:
  - Waits for the first change between two valid phases. On it, go to TRACK with run=1.
  - The partial phase seen before lock is not duration-checked.
- TRACK, at a valid phase change (old phase -> new phase):
  - Successor must be the legal one (RED->GREEN, GREEN->YELLOW, YELLOW->RED); otherwise set err_seq.
  - Completed run must equal the old phase's *_TIME; otherwise set err_dur.
  - dur_last <= run.
  - On YELLOW->RED, cycle_count increments and wraps modulo 2^CYC_W.
- TRACK, stuck light: if the run reaches *_TIME+1 with no change, set err_dur on that cycle (do not wait for the transition).
- TRACK, INVALID decode: set err_onehot.
- Any error set in TRACK: go to FAULT, locked=0, fault_pulse=1 for exactly one cycle.
- SYNC and FAULT: INVALID decode sets err_onehot. No other checks run, and there is no fault_pulse outside the TRACK->FAULT entry.
- FAULT: holds all outputs except phase and dur_last. Left only via clr_err or rst.
- clr_err=1 in any state:
  - Clears err_* and goes to SYNC.
  - If an error is detected in the same cycle, set wins: that flag stays 1 and the state is still SYNC.
  - cycle_count is not cleared.
- A simultaneous sequence and duration violation sets both flags; a single fault_pulse is issued.
- rst mid-operation overrides clr_err and all detection; outputs return to reset values on the next edge.

Decomposition:
- Package traffic_light_pkg holds:
  - phase encoding constants S_RED=2'b00, S_GREEN=2'b01, S_YELLOW=2'b10, S_INVALID=2'b11, shared with the controller;
  - monitor state constants SYNC/TRACK/FAULT;
  - function legal_next(phase) and function expected_time(phase).
- One sub-module, light_decode: a combinational 3-bit light vector -> 2-bit phase decoder, reusable by other observers.
- Rest stays in the top: FSM, run counter, flag registers.

Test Plan:
- Nominal: from reset drive 4 full periods RED10/GREEN8/YELLOW3, then RED -> locked=1 from first R->G, cycle_count=4, all err_*=0, dur_last=3 after final Y->R.
- Stuck red after lock: RED held 20 cycles -> err_dur=1 when run=11, single fault_pulse, locked=0, later GREEN raises no new pulse.
- Short green 7 then YELLOW -> err_dur=1 at the G->Y boundary, dur_last=7, err_seq=0.
- Skipped yellow, GREEN8 then RED -> err_seq=1, err_dur=0; two lights 110 for one cycle -> err_onehot=1, phase=11 for one cycle.
- In FAULT assert clr_err one cycle -> all err_*=0, state SYNC, locked=1 at next valid boundary, cycle_count retained. clr_err coincident with lights=011 -> err_onehot remains 1.
- rst pulse mid-GREEN while locked with cycle_count=2 -> next cycle: all outputs at reset values, relock at following boundary.
